// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the MIPS datapath: decodes the ID-stage instruction
// and registers operands, extended immediate and control bits for EX.
module id_ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [31:0] id_instr,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic        stall,
    input  logic        flush,
    output logic        ex_valid,
    output logic [31:0] ex_rs_out,
    output logic [31:0] ex_rt_out,
    output logic [31:0] ex_sign_out,
    output logic        ex_alu_src,
    output logic [3:0]  ex_alu_op,
    output logic [5:0]  ex_funct,
    output logic [4:0]  ex_shamt,
    output logic [4:0]  ex_dest,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        ex_mem_to_reg,
    output logic        ex_branch,
    output logic        ex_illegal
);
    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_SLT   = 4'b0100;
    localparam logic [3:0] ALU_PASSB = 4'b0101;
    localparam logic [3:0] ALU_FUNCT = 4'b1111;

    logic [5:0]  opcode;
    logic [4:0]  rt, rd;
    logic [31:0] sext, zext, upper;

    logic        d_alu_src;
    logic [3:0]  d_alu_op;
    logic [4:0]  d_dest;
    logic        d_reg_write, d_mem_read, d_mem_write, d_mem_to_reg, d_branch, d_illegal;
    logic [31:0] d_imm;

    assign opcode = id_instr[31:26];
    assign rt     = id_instr[20:16];
    assign rd     = id_instr[15:11];
    assign sext   = {{16{id_instr[15]}}, id_instr[15:0]};
    assign zext   = {16'h0000, id_instr[15:0]};
    assign upper  = {id_instr[15:0], 16'h0000};

    always_comb begin
        d_alu_src    = 1'b0;
        d_alu_op     = ALU_ADD;
        d_dest       = 5'd0;
        d_reg_write  = 1'b0;
        d_mem_read   = 1'b0;
        d_mem_write  = 1'b0;
        d_mem_to_reg = 1'b0;
        d_branch     = 1'b0;
        d_illegal    = 1'b0;
        d_imm        = sext;
        case (opcode)
            6'h00: begin
                d_alu_op    = ALU_FUNCT;
                d_dest      = rd;
                d_reg_write = 1'b1;
            end
            6'h23: begin
                d_alu_src    = 1'b1;
                d_dest       = rt;
                d_reg_write  = 1'b1;
                d_mem_read   = 1'b1;
                d_mem_to_reg = 1'b1;
            end
            6'h2B: begin
                d_alu_src   = 1'b1;
                d_mem_write = 1'b1;
            end
            6'h04: begin
                d_alu_op = ALU_SUB;
                d_branch = 1'b1;
            end
            6'h08: begin
                d_alu_src   = 1'b1;
                d_dest      = rt;
                d_reg_write = 1'b1;
            end
            6'h0A: begin
                d_alu_src   = 1'b1;
                d_alu_op    = ALU_SLT;
                d_dest      = rt;
                d_reg_write = 1'b1;
            end
            6'h0C: begin
                d_alu_src   = 1'b1;
                d_alu_op    = ALU_AND;
                d_dest      = rt;
                d_reg_write = 1'b1;
                d_imm       = zext;
            end
            6'h0D: begin
                d_alu_src   = 1'b1;
                d_alu_op    = ALU_OR;
                d_dest      = rt;
                d_reg_write = 1'b1;
                d_imm       = zext;
            end
            6'h0F: begin
                d_alu_src   = 1'b1;
                d_alu_op    = ALU_PASSB;
                d_dest      = rt;
                d_reg_write = 1'b1;
                d_imm       = upper;
            end
            default: d_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            ex_valid      <= 1'b0;
            ex_rs_out     <= 32'd0;
            ex_rt_out     <= 32'd0;
            ex_sign_out   <= 32'd0;
            ex_alu_src    <= 1'b0;
            ex_alu_op     <= 4'd0;
            ex_funct      <= 6'd0;
            ex_shamt      <= 5'd0;
            ex_dest       <= 5'd0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_branch     <= 1'b0;
            ex_illegal    <= 1'b0;
        end else if (!stall) begin
            // Operand data loads even for an invalid slot; only decode results are gated.
            ex_rs_out     <= id_rs_data;
            ex_rt_out     <= id_rt_data;
            ex_sign_out   <= d_imm;
            ex_valid      <= id_valid;
            ex_alu_src    <= id_valid & d_alu_src;
            ex_alu_op     <= id_valid ? d_alu_op : 4'd0;
            ex_funct      <= id_valid ? id_instr[5:0] : 6'd0;
            ex_shamt      <= id_valid ? id_instr[10:6] : 5'd0;
            ex_dest       <= id_valid ? d_dest : 5'd0;
            ex_reg_write  <= id_valid & d_reg_write;
            ex_mem_read   <= id_valid & d_mem_read;
            ex_mem_write  <= id_valid & d_mem_write;
            ex_mem_to_reg <= id_valid & d_mem_to_reg;
            ex_branch     <= id_valid & d_branch;
            ex_illegal    <= id_valid & d_illegal;
        end
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage.
module tb_id_ex_stage;
    logic        clk = 1'b0;
    logic        rst, id_valid, stall, flush;
    logic [31:0] id_instr, id_rs_data, id_rt_data;
    logic        ex_valid, ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write;
    logic        ex_mem_to_reg, ex_branch, ex_illegal;
    logic [31:0] ex_rs_out, ex_rt_out, ex_sign_out;
    logic [3:0]  ex_alu_op;
    logic [5:0]  ex_funct;
    logic [4:0]  ex_shamt, ex_dest;

    int checks = 0;
    int errors = 0;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .ex_rs_out(ex_rs_out), .ex_rt_out(ex_rt_out),
        .ex_sign_out(ex_sign_out), .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op),
        .ex_funct(ex_funct), .ex_shamt(ex_shamt), .ex_dest(ex_dest),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch), .ex_illegal(ex_illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [130:0] all_out();
        return {ex_valid, ex_rs_out, ex_rt_out, ex_sign_out, ex_alu_src, ex_alu_op, ex_funct,
                ex_shamt, ex_dest, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
                ex_branch, ex_illegal};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic v, input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
        id_valid = v; id_instr = ins; id_rs_data = rs; id_rt_data = rt;
        tick();
    endtask

    task automatic test_reset();
        rst = 1; id_valid = 0; id_instr = 0; id_rs_data = 0; id_rt_data = 0; stall = 0; flush = 0;
        tick(); tick();
        checks++; if (all_out() !== '0) begin errors++; $display("FAIL reset_all got %h want 0", all_out()); end
        rst = 0;
        tick(); tick();
        checks++; if (all_out() !== '0) begin errors++; $display("FAIL release_all got %h want 0", all_out()); end
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL release_valid got %b want 0", ex_valid); end
    endtask

    task automatic test_addi();
        load(1, 32'h2109FFFC, 32'h10, 32'h55);
        checks++; if (ex_alu_src !== 1'b1) begin errors++; $display("FAIL addi_src got %b want 1", ex_alu_src); end
        checks++; if (ex_sign_out !== 32'hFFFFFFFC) begin errors++; $display("FAIL addi_imm got %h want fffffffc", ex_sign_out); end
        checks++; if (ex_alu_op !== 4'b0000) begin errors++; $display("FAIL addi_op got %b want 0000", ex_alu_op); end
        checks++; if (ex_dest !== 5'd9) begin errors++; $display("FAIL addi_dest got %0d want 9", ex_dest); end
        checks++; if (ex_reg_write !== 1'b1) begin errors++; $display("FAIL addi_rw got %b want 1", ex_reg_write); end
        checks++; if (ex_rs_out !== 32'h10) begin errors++; $display("FAIL addi_rs got %h want 10", ex_rs_out); end
        checks++; if (ex_rt_out !== 32'h55) begin errors++; $display("FAIL addi_rt got %h want 55", ex_rt_out); end
        checks++; if (ex_valid !== 1'b1 || ex_illegal !== 1'b0) begin errors++; $display("FAIL addi_valid got %b%b want 10", ex_valid, ex_illegal); end
    endtask

    task automatic test_immediates();
        load(1, 32'h35098001, 0, 0);
        checks++; if (ex_sign_out !== 32'h00008001) begin errors++; $display("FAIL ori_imm got %h want 00008001", ex_sign_out); end
        checks++; if (ex_alu_op !== 4'b0011) begin errors++; $display("FAIL ori_op got %b want 0011", ex_alu_op); end
        load(1, 32'h3C091234, 0, 0);
        checks++; if (ex_sign_out !== 32'h12340000) begin errors++; $display("FAIL lui_imm got %h want 12340000", ex_sign_out); end
        checks++; if (ex_alu_op !== 4'b0101) begin errors++; $display("FAIL lui_op got %b want 0101", ex_alu_op); end
        load(1, 32'h3109F00F, 0, 0); // andi $t1,$t0,0xF00F
        checks++; if ({ex_sign_out, ex_alu_op} !== {32'h0000F00F, 4'b0010}) begin errors++; $display("FAIL andi got %h/%b want 0000f00f/0010", ex_sign_out, ex_alu_op); end
        load(1, 32'h2909FFFF, 0, 0); // slti $t1,$t0,-1
        checks++; if ({ex_sign_out, ex_alu_op} !== {32'hFFFFFFFF, 4'b0100}) begin errors++; $display("FAIL slti got %h/%b want ffffffff/0100", ex_sign_out, ex_alu_op); end
    endtask

    task automatic test_mem_branch();
        load(1, 32'h8D090008, 0, 0); // lw $t1,8($t0)
        checks++; if ({ex_mem_read, ex_mem_to_reg, ex_reg_write, ex_mem_write, ex_alu_src, ex_dest} !== {5'b11101, 5'd9})
            begin errors++; $display("FAIL lw_ctl got %b%b%b%b%b/%0d want 11101/9", ex_mem_read, ex_mem_to_reg, ex_reg_write, ex_mem_write, ex_alu_src, ex_dest); end
        load(1, 32'h1109FFFF, 0, 0); // beq $t0,$t1,-1
        checks++; if ({ex_branch, ex_reg_write, ex_alu_src, ex_alu_op, ex_sign_out} !== {3'b100, 4'b0001, 32'hFFFFFFFF})
            begin errors++; $display("FAIL beq got %b%b%b/%b/%h want 100/0001/ffffffff", ex_branch, ex_reg_write, ex_alu_src, ex_alu_op, ex_sign_out); end
    endtask

    task automatic test_stall_flush();
        load(1, 32'h01095020, 32'hA, 32'hB);
        checks++; if ({ex_alu_src, ex_alu_op, ex_funct, ex_dest} !== {1'b0, 4'b1111, 6'h20, 5'd10})
            begin errors++; $display("FAIL add_dec got %b/%b/%h/%0d want 0/1111/20/10", ex_alu_src, ex_alu_op, ex_funct, ex_dest); end
        stall = 1;
        for (int i = 0; i < 2; i++) begin
            load(1, 32'hAD090004, 32'h77, 32'h88);
            checks++; if ({ex_funct, ex_dest, ex_alu_op, ex_mem_write, ex_rs_out} !== {6'h20, 5'd10, 4'b1111, 1'b0, 32'hA})
                begin errors++; $display("FAIL stall_hold%0d got %h/%0d/%b/%b/%h want 20/10/1111/0/a", i, ex_funct, ex_dest, ex_alu_op, ex_mem_write, ex_rs_out); end
        end
        flush = 1;
        tick();
        checks++; if ({ex_valid, ex_reg_write, ex_mem_write} !== 3'b000)
            begin errors++; $display("FAIL flush_bubble got %b%b%b want 000", ex_valid, ex_reg_write, ex_mem_write); end
        stall = 0; flush = 0;
        tick(); // sw now loads
        checks++; if ({ex_valid, ex_mem_write, ex_reg_write, ex_rs_out} !== {3'b110, 32'h77})
            begin errors++; $display("FAIL resume_sw got %b%b%b/%h want 110/77", ex_valid, ex_mem_write, ex_reg_write, ex_rs_out); end
        load(0, 32'h2109FFFC, 32'h33, 0);
        checks++; if ({ex_valid, ex_reg_write, ex_rs_out} !== {2'b00, 32'h33})
            begin errors++; $display("FAIL invalid_slot got %b%b/%h want 00/33", ex_valid, ex_reg_write, ex_rs_out); end
    endtask

    task automatic test_illegal();
        load(1, 32'hFC000000, 0, 0);
        checks++; if ({ex_illegal, ex_valid} !== 2'b11) begin errors++; $display("FAIL ill_flag got %b%b want 11", ex_illegal, ex_valid); end
        checks++; if ({ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch} !== 5'b0)
            begin errors++; $display("FAIL ill_ctl got %b%b%b%b%b want 00000", ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch); end
        load(1, 32'h2109FFFC, 32'h10, 32'h55);
        stall = 1; rst = 1;
        tick();
        checks++; if (all_out() !== '0) begin errors++; $display("FAIL rst_clear got %h want 0", all_out()); end
        rst = 0; stall = 0;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_immediates();
        test_mem_branch();
        test_stall_flush();
        test_illegal();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
